// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     state_t : FSM encoding (IDLE / SHIFT / DONE)
//     cnt_w() : width of the bit counter for a given operand width
//   Legal operand widths are bounded by MIN_WIDTH..MAX_WIDTH.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_w(8);

endpackage

// File: rtl/fa.sv
// -----------------------------------------------------------------------------
// fa
//   1-bit full adder cell.
//   Ports:
//     a, b  : addend bits
//     cin   : carry in
//     s     : sum bit  (a ^ b ^ cin)
//     cout  : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are captured on an input valid/ready
//   handshake, fed LSB-first through a single full adder cell (one bit per
//   clock, carry registered between bits), and the WIDTH-bit sum plus carry-out
//   are presented on an output valid/ready handshake and held until taken.
//
//   Ports:
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : a, b, cin valid this cycle
//     in_ready  : high only while idle
//     a, b      : WIDTH-bit operands
//     cin       : carry into bit 0
//     out_valid : sum/cout valid and held
//     out_ready : consumer accepts the result
//     sum       : (a + b + cin) mod 2^WIDTH, zero when no result is presented
//     cout      : carry out of bit WIDTH-1, zero when no result is presented
//
//   Timing: accept on edge E0, SHIFT on edges E1..E(WIDTH), out_valid high
//   after E(WIDTH). Minimum throughput one operation per WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   count;

  logic               fa_s;
  logic               fa_co;

  logic               accept;
  logic               last_bit;
  logic               drain;

  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && (count == LAST_BIT);
  assign drain    = out_valid && out_ready;

  // Single bit-slice: always looks at the current LSBs plus the stored carry.
  fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (drain)    state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (Moore). Result lines are forced to zero outside DONE
  // so a consumer never sees the partially shifted sum.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        sum       = sum_sh;
        cout      = carry;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, sum shifter, carry and bit counter.
  // The sum fills from the MSB end, so after WIDTH shifts bit 0 of the result
  // has arrived at sum_sh[0]. Carry is left alone in DONE so it doubles as cout.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      carry  <= cin;
      count  <= '0;
    end else if (state == SHIFT) begin
      sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_co;
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;

  // WIDTH=4 instance
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  int hs4 = 0;
  always @(posedge clk) begin
    if (rst_n && out_valid4 && out_ready4) hs4 <= hs4 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 op and wait for out_valid. Returns with DUT in DONE.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input string tag, output logic [8:0] exp_o);
    int cyc;
    logic busy_ready;
    logic [8:0] exp;
    cyc = 0;
    while (!in_ready8 && cyc < 40) begin tick(); cyc++; end
    chk({tag, "_in_ready"}, 32'(in_ready8), 32'd1);
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    exp = 9'(a) + 9'(b) + 9'(c);
    exp_o = exp;
    q8.push_back(exp);
    tick();
    // Scramble inputs after acceptance: only the accept-edge values matter.
    in_valid8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    busy_ready = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 40) begin
      busy_ready |= in_ready8;
      tick();
      cyc++;
    end
    busy_ready |= in_ready8;
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_busy_in_ready"}, 32'(busy_ready), 32'd0);
    if (out_valid8 && q8.size() > 0) begin
      exp = q8.pop_front();
      chk({tag, "_result"}, 32'({cout8, sum8}), 32'(exp));
    end
  endtask

  // Complete the output handshake with out_ready already high.
  task automatic drain8(input string tag);
    tick();
    chk({tag, "_out_valid_drop"}, 32'(out_valid8), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    logic [8:0] e8;
    logic [8:0] v;
    logic [4:0] e4;
    int cyc;
    bit done;

    rst_n = 1'b0;
    in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; out_ready8 = 1;
    in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 0;
    #12;
    chk("rst_in_ready",  32'(in_ready8),  32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_sum",       32'(sum8),       32'd0);
    chk("rst_cout",      32'(cout8),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic adds
    op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c", e8);
    chk("add_5a_3c_const", 32'({cout8, sum8}), 32'h096);
    drain8("add_5a_3c");
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01", e8);
    chk("add_ff_01_const", 32'({cout8, sum8}), 32'h100);
    drain8("add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_1", e8);
    chk("add_ff_ff_1_const", 32'({cout8, sum8}), 32'h1FF);
    drain8("add_ff_ff_1");

    // Backpressure: result held, new operand ignored while busy
    out_ready8 = 1'b0;
    op8(8'h80, 8'h80, 1'b1, "bp", e8);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid8), 32'd1);
      chk("bp_hold_result", 32'({cout8, sum8}), 32'(e8));
      chk("bp_hold_in_ready", 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    drain8("bp");
    tick(); tick(); tick();
    chk("bp_ignored_no_output", 32'(out_valid8), 32'd0);
    chk("bp_ignored_idle", 32'(in_ready8), 32'd1);
    op8(8'h11, 8'h22, 1'b0, "bp_represent", e8);
    chk("bp_represent_const", 32'({cout8, sum8}), 32'h033);
    drain8("bp_represent");

    // Asynchronous reset in the middle of SHIFT
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid8), 32'd0);
    chk("midrst_sum",       32'(sum8),       32'd0);
    chk("midrst_cout",      32'(cout8),      32'd0);
    chk("midrst_in_ready",  32'(in_ready8),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op8(8'h0F, 8'h01, 1'b0, "post_rst", e8);
    chk("post_rst_const", 32'({cout8, sum8}), 32'h010);
    drain8("post_rst");

    // WIDTH=4 exhaustive with random output stalls
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      cyc = 0;
      while (!in_ready4 && cyc < 40) begin tick(); cyc++; end
      if (!in_ready4) chk("w4_accept_timeout", 32'(in_ready4), 32'd1);
      a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; in_valid4 = 1'b1;
      q4.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
      tick();
      in_valid4 = 1'b0;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 64) begin
        out_ready4 = 1'($urandom_range(0, 1));
        if (out_valid4 && out_ready4) begin
          e4 = q4.pop_front();
          chk("w4_result", 32'({cout4, sum4}), 32'(e4));
          done = 1'b1;
        end
        tick();
        cyc++;
      end
      if (!done) chk("w4_result_timeout", 32'(done), 32'd1);
    end
    out_ready4 = 1'b0;
    tick(); tick();
    chk("w4_handshake_count", 32'(hs4), 32'd512);
    chk("w4_queue_empty", 32'(q4.size()), 32'd0);
    chk("w8_queue_empty", 32'(q8.size()), 32'd0);
    chk("w4_no_extra_valid", 32'(out_valid4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
